// File: rtl/uart_rx_buffered_if.sv
// Read-side bus of uart_rx_buffered: show-ahead byte, valid/ready pop strobe, occupancy, frame error.
// Overrun is present only when UART_RX_OVERRUN_EN is defined.
interface uart_rx_buffered_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]      DataOut;
  logic            DataOutValid;
  logic            DataOutReady;
  logic [CntW-1:0] Count;
  logic            FrameErr;
`ifdef UART_RX_OVERRUN_EN
  logic            Overrun;

  modport master (output DataOut, DataOutValid, Count, FrameErr, Overrun, input DataOutReady);
  modport slave  (input DataOut, DataOutValid, Count, FrameErr, Overrun, output DataOutReady);
`else
  modport master (output DataOut, DataOutValid, Count, FrameErr, input DataOutReady);
  modport slave  (input DataOut, DataOutValid, Count, FrameErr, output DataOutReady);
`endif
endinterface

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO; optional sticky Overrun flag
// when UART_RX_OVERRUN_EN is defined.
module uart_rx_buffered #(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               SIn,
  uart_rx_buffered_if.master rd
);
  localparam int unsigned BitTime = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned ClkW    = $clog2(BitTime);
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam logic [ClkW-1:0] HalfLast = ClkW'(BitTime / 2 - 1);
  localparam logic [ClkW-1:0] BitLast  = ClkW'(BitTime - 1);
  localparam logic [CntW-1:0] Full     = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic            sync_q, rx_q, rx_prev_q;
  state_e          state_q, state_d;
  logic [ClkW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            stop_ok, stop_bad;
  logic            frame_err_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync_q    <= 1'b1;
      rx_q      <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= SIn;
      rx_q      <= sync_q;
      rx_prev_q <= rx_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        if (rx_prev_q && !rx_q) state_d = StStart;
      end
      StStart: begin
        if (clk_cnt_q == HalfLast) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_q ? StIdle : StData;
        end
      end
      StData: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          shift_d   = {rx_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        // Back to idle on the sample cycle so a start edge half a bit later is seen.
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          state_d   = StIdle;
          stop_ok   = rx_q;
          stop_bad  = !rx_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= stop_bad;
    end
  end

  always_comb begin
    pop     = rd.DataOutReady && (count_q != '0);
    push    = stop_ok && ((count_q < Full) || pop);
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rd.DataOut      = mem_q[rd_ptr_q];
  assign rd.DataOutValid = (count_q != '0);
  assign rd.Count        = count_q;
  assign rd.FrameErr     = frame_err_q;

`ifdef UART_RX_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset)                        overrun_q <= 1'b0;
    else if (pop && overrun_q)        overrun_q <= 1'b0;
    else if (stop_ok && !push)        overrun_q <= 1'b1;
  end

  assign rd.Overrun = overrun_q;
`endif
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: frames are driven bit by bit, expected bytes are
// queued at issue time and a negedge monitor checks every popped byte.
module tb_uart_rx_buffered;
  localparam int unsigned Depth = 4;

  logic CLK = 1'b0;
  logic reset;
  logic SIn;

  uart_rx_buffered_if #(.FIFO_DEPTH(Depth)) rd_if ();

  uart_rx_buffered #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100),
    .FIFO_DEPTH(Depth)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .SIn  (SIn),
    .rd   (rd_if)
  );

  always #5 CLK = ~CLK;

  int         total   = 0;
  int         bad     = 0;
  int         fe_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every accepted pop must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (!reset) begin
      if (rd_if.FrameErr) fe_seen++;
      if (rd_if.DataOutValid && rd_if.DataOutReady) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got 0x%0h want no data", rd_if.DataOut);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("pop_data", int'(rd_if.DataOut), int'(mon_exp));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Called just after a posedge; k counts cycles from the start bit. Stop mid-sample is edge 98.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_push,
                            input bit pop_at_stop, input bit check_lat, input int abort_k);
    if (expect_push) exp_q.push_back(b);
    SIn = 1'b0;
    for (int k = 1; k < 100; k++) begin
      tick();
      if (k == abort_k) begin
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("rst_valid", int'(rd_if.DataOutValid), 0);
        chk("rst_count", int'(rd_if.Count), 0);
        chk("rst_data", int'(rd_if.DataOut), 0);
        chk("rst_frameerr", int'(rd_if.FrameErr), 0);
        SIn = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        return;
      end
      if (k < 10)      SIn = 1'b0;
      else if (k < 90) SIn = b[k/10-1];
      else             SIn = stop;
      if (pop_at_stop) rd_if.DataOutReady = (k == 97);
      if (check_lat && k == 97) chk("lat_valid_before", int'(rd_if.DataOutValid), 0);
      if (check_lat && k == 98) begin
        chk("lat_valid_after", int'(rd_if.DataOutValid), 1);
        chk("lat_data", int'(rd_if.DataOut), int'(b));
        chk("lat_count", int'(rd_if.Count), 1);
      end
      if (!stop && k == 98) chk("ferr_pulse", int'(rd_if.FrameErr), 1);
      if (!stop && k == 99) chk("ferr_end", int'(rd_if.FrameErr), 0);
    end
    tick();
    SIn = 1'b1;
  endtask

  task automatic pop_one();
    rd_if.DataOutReady = 1'b1;
    tick();
    rd_if.DataOutReady = 1'b0;
    tick();
  endtask

  int fe0;

  initial begin
    reset = 1'b1;
    SIn   = 1'b1;
    rd_if.DataOutReady = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_data", int'(rd_if.DataOut), 0);
    chk("reset_valid", int'(rd_if.DataOutValid), 0);
    chk("reset_count", int'(rd_if.Count), 0);
    chk("reset_frameerr", int'(rd_if.FrameErr), 0);
`ifdef UART_RX_OVERRUN_EN
    chk("reset_overrun", int'(rd_if.Overrun), 0);
`endif
    reset = 1'b0;
    repeat (5) tick();

    // Single frame with latency checks, then one pop.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    repeat (5) tick();
    pop_one();
    chk("single_valid_after_pop", int'(rd_if.DataOutValid), 0);
    chk("single_count_after_pop", int'(rd_if.Count), 0);

    // Five back-to-back frames into a depth-4 FIFO: the fifth is dropped.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, (i <= 4), 1'b0, 1'b0, -1);
    repeat (3) tick();
    chk("b2b_count", int'(rd_if.Count), 4);
    chk("b2b_head", int'(rd_if.DataOut), 8'h01);
`ifdef UART_RX_OVERRUN_EN
    chk("b2b_overrun_set", int'(rd_if.Overrun), 1);
`endif
    pop_one();
`ifdef UART_RX_OVERRUN_EN
    chk("b2b_overrun_clr", int'(rd_if.Overrun), 0);
`endif
    repeat (3) pop_one();
    chk("b2b_valid_empty", int'(rd_if.DataOutValid), 0);
    pop_one();
    chk("empty_pop_count", int'(rd_if.Count), 0);

    // Three-cycle low glitch must not produce a byte or a frame error.
    fe0 = fe_seen;
    SIn = 1'b0;
    repeat (3) tick();
    SIn = 1'b1;
    repeat (20) tick();
    chk("glitch_count", int'(rd_if.Count), 0);
    chk("glitch_ferr", fe_seen - fe0, 0);

    // Bad stop bit, then a good frame.
    fe0 = fe_seen;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    repeat (3) tick();
    chk("ferr_cycles", fe_seen - fe0, 1);
    chk("ferr_count", int'(rd_if.Count), 0);
    send_frame(8'h7E, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    repeat (3) tick();
    chk("after_ferr_count", int'(rd_if.Count), 1);
    pop_one();

    // Full FIFO with a pop on the same edge as the fifth push.
    send_frame(8'h11, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'h33, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'h44, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'h55, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    repeat (3) tick();
    chk("full_pp_count", int'(rd_if.Count), 4);
    chk("full_pp_head", int'(rd_if.DataOut), 8'h22);
`ifdef UART_RX_OVERRUN_EN
    chk("full_pp_overrun", int'(rd_if.Overrun), 0);
`endif
    repeat (4) pop_one();
    chk("full_pp_empty", int'(rd_if.DataOutValid), 0);

    // Reset at bit 4 of a frame with two bytes queued.
    send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'h42, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 50);
    repeat (150) tick();
    chk("post_rst_count", int'(rd_if.Count), 0);
    send_frame(8'h6B, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    repeat (3) tick();
    chk("post_rst_rx_count", int'(rd_if.Count), 1);
    pop_one();
    chk("post_rst_empty", int'(rd_if.DataOutValid), 0);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
